// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages (IF and ID).
// Contents: datapath width, instruction-memory address width, the special
// HALT/NOP encodings, primary opcode values used by decode, and the IF FSM
// state type.
package mips_pkg;

  localparam int          LEN         = 32;
  localparam int          NB_ADDR_MEM = 10;

  localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

  // Primary opcodes (instr[31:26]) consumed by the decode stage.
  localparam logic [5:0]  OP_RTYPE    = 6'h00;
  localparam logic [5:0]  OP_J        = 6'h02;
  localparam logic [5:0]  OP_JAL      = 6'h03;
  localparam logic [5:0]  OP_BEQ      = 6'h04;
  localparam logic [5:0]  OP_BNE      = 6'h05;
  localparam logic [5:0]  OP_ADDI     = 6'h08;
  localparam logic [5:0]  OP_LW       = 6'h23;
  localparam logic [5:0]  OP_SW       = 6'h2B;

  typedef enum logic {
    IF_RUN    = 1'b0,
    IF_HALTED = 1'b1
  } if_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory.
// Ports:
//   i_clk      write clock
//   i_wr_en    synchronous write strobe (debug program load)
//   i_wr_addr  write word address
//   i_wr_data  write data
//   i_rd_addr  read word address (combinational read)
//   o_rd_data  read data; a word written this cycle reads old data until the edge
module instruction_memory #(
  parameter int NB_ADDR_MEM = 10,
  parameter int LEN         = 32
) (
  input  logic                   i_clk,
  input  logic                   i_wr_en,
  input  logic [NB_ADDR_MEM-1:0] i_wr_addr,
  input  logic [LEN-1:0]         i_wr_data,
  input  logic [NB_ADDR_MEM-1:0] i_rd_addr,
  output logic [LEN-1:0]         o_rd_data
);

  localparam int DEPTH = 1 << NB_ADDR_MEM;

  logic [LEN-1:0] mem_q [DEPTH];

  // No reset: the loaded program survives a pipeline reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/seg_instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline.
// Holds the PC, the instruction memory and the IF/ID latch {PC+4, instruction}.
// Ports:
//   i_clk, i_rst        clock / async active-low reset
//   i_enable            global step enable (0 freezes everything but memory writes)
//   i_stall_flag        load-use stall from ID: PC and IF/ID hold
//   i_jump_flag         taken jump/branch from ID, target in i_PC_dir_jump
//   i_flush             squash IF/ID contents to NOP
//   i_wr_en/addr/data   debug program-load port into instruction memory
//   o_PC                IF/ID PC+4
//   o_instruction       IF/ID instruction
//   o_halt              sticky, set when HALT_WORD is latched into IF/ID
//   o_pc_fetch          current PC register
module seg_instruction_fetch #(
  parameter int             LEN         = mips_pkg::LEN,
  parameter int             NB_ADDR_MEM = mips_pkg::NB_ADDR_MEM,
  parameter logic [LEN-1:0] HALT_WORD   = mips_pkg::HALT_WORD,
  parameter logic [LEN-1:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_stall_flag,
  input  logic                   i_jump_flag,
  input  logic [LEN-1:0]         i_PC_dir_jump,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [NB_ADDR_MEM-1:0] i_wr_addr,
  input  logic [LEN-1:0]         i_wr_data,
  output logic [LEN-1:0]         o_PC,
  output logic [LEN-1:0]         o_instruction,
  output logic                   o_halt,
  output logic [LEN-1:0]         o_pc_fetch
);

  import mips_pkg::*;

  if_state_e      state_q;
  logic [LEN-1:0] pc_q;
  logic [LEN-1:0] pc_d;
  logic [LEN-1:0] pc_plus4;
  logic [LEN-1:0] ifid_pc_q;
  logic [LEN-1:0] ifid_instr_q;
  logic           halt_q;
  logic [LEN-1:0] fetch;

  instruction_memory #(
    .NB_ADDR_MEM (NB_ADDR_MEM),
    .LEN         (LEN)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (pc_q[NB_ADDR_MEM+1:2]),
    .o_rd_data (fetch)
  );

  assign pc_plus4 = pc_q + LEN'(4);
  assign pc_d     = i_jump_flag ? i_PC_dir_jump : pc_plus4;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IF_RUN;
      pc_q         <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_WORD;
      halt_q       <= 1'b0;
    end else if (i_enable && (state_q == IF_RUN)) begin
      if (i_stall_flag) begin
        // Jump is dropped here; ID re-asserts it once the stall clears.
        if (i_flush) begin
          ifid_instr_q <= NOP_WORD;
        end
      end else begin
        pc_q      <= pc_d;
        ifid_pc_q <= pc_plus4;
        if (i_flush || i_jump_flag) begin
          // Wrong-path fetch: squashed, so a HALT here must not stop the core.
          ifid_instr_q <= NOP_WORD;
        end else begin
          ifid_instr_q <= fetch;
          if (fetch == HALT_WORD) begin
            halt_q  <= 1'b1;
            state_q <= IF_HALTED;
          end
        end
      end
    end
  end

  assign o_PC          = ifid_pc_q;
  assign o_instruction = ifid_instr_q;
  assign o_halt        = halt_q;
  assign o_pc_fetch    = pc_q;

endmodule

// File: tb/tb_seg_instruction_fetch.sv
module tb_seg_instruction_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_stall_flag;
  logic        i_jump_flag;
  logic [31:0] i_PC_dir_jump;
  logic        i_flush;
  logic        i_wr_en;
  logic [9:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic [31:0] o_PC;
  logic [31:0] o_instruction;
  logic        o_halt;
  logic [31:0] o_pc_fetch;

  seg_instruction_fetch dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_stall_flag  (i_stall_flag),
    .i_jump_flag   (i_jump_flag),
    .i_PC_dir_jump (i_PC_dir_jump),
    .i_flush       (i_flush),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .o_PC          (o_PC),
    .o_instruction (o_instruction),
    .o_halt        (o_halt),
    .o_pc_fetch    (o_pc_fetch)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        halt;
    logic [31:0] pcf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are stable at the falling edge; compare against the
  // oldest pending expectation.
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (o_PC !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_pc_fetch !== e.pcf) begin
        errors++;
        $display("FAIL %s: got PC=%h ins=%h halt=%b pcf=%h, expected PC=%h ins=%h halt=%b pcf=%h",
                 e.name, o_PC, o_instruction, o_halt, o_pc_fetch, e.pc, e.ins, e.halt, e.pcf);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] ins,
                            input logic halt, input logic [31:0] pcf);
    exp_t e;
    e.name = name; e.pc = pc; e.ins = ins; e.halt = halt; e.pcf = pcf;
    exp_q.push_back(e);
  endtask

  // One clock with the given controls; the expected post-edge outputs are queued first.
  task automatic step(input logic en, input logic stall, input logic jump, input logic [31:0] tgt,
                      input logic flush, input string name, input logic [31:0] pc,
                      input logic [31:0] ins, input logic halt, input logic [31:0] pcf);
    i_enable = en; i_stall_flag = stall; i_jump_flag = jump; i_PC_dir_jump = tgt; i_flush = flush;
    expect_out(name, pc, ins, halt, pcf);
    tick();
  endtask

  task automatic run(input string name, input logic [31:0] pc, input logic [31:0] ins,
                     input logic halt, input logic [31:0] pcf);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, name, pc, ins, halt, pcf);
  endtask

  task automatic load(input logic [9:0] addr, input logic [31:0] data);
    i_enable = 1'b0; i_stall_flag = 1'b0; i_jump_flag = 1'b0; i_flush = 1'b0;
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic do_reset(input string name);
    i_rst = 1'b0;
    i_enable = 1'b1; i_stall_flag = 1'b0; i_jump_flag = 1'b0; i_flush = 1'b0;
    expect_out(name, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    i_rst = 1'b1;
  endtask

  initial begin
    i_rst = 1'b0; i_enable = 1'b0; i_stall_flag = 1'b0; i_jump_flag = 1'b0;
    i_PC_dir_jump = '0; i_flush = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;

    // 1: reset, load program, run to HALT
    do_reset("reset_initial");
    load(10'd0, 32'h0109_4020);
    load(10'd1, 32'h8C22_0004);
    load(10'd2, 32'h0000_0000);
    load(10'd3, 32'hFFFF_FFFF);
    load(10'd16, 32'h1111_1111);
    load(10'd17, 32'h2222_2222);
    run("seq_pc0",  32'd4,  32'h0109_4020, 1'b0, 32'd4);
    run("seq_pc4",  32'd8,  32'h8C22_0004, 1'b0, 32'd8);
    run("seq_pc8",  32'd12, 32'h0000_0000, 1'b0, 32'd12);
    run("seq_halt", 32'd16, 32'hFFFF_FFFF, 1'b1, 32'd16);
    run("halted_1", 32'd16, 32'hFFFF_FFFF, 1'b1, 32'd16);
    run("halted_2", 32'd16, 32'hFFFF_FFFF, 1'b1, 32'd16);

    // 6: reset while halted, program preserved
    do_reset("reset_from_halt");

    // 2: jump at PC=8 to 0x40
    run("j_pc0", 32'd4, 32'h0109_4020, 1'b0, 32'd4);
    run("j_pc4", 32'd8, 32'h8C22_0004, 1'b0, 32'd8);
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, "j_redirect", 32'd12, 32'h0, 1'b0, 32'h40);
    run("j_target",  32'h44, 32'h1111_1111, 1'b0, 32'h44);
    run("j_target2", 32'h48, 32'h2222_2222, 1'b0, 32'h48);

    // 3: stall with jump at PC=4, then stall+flush, then resume
    do_reset("reset_stall");
    run("s_pc0", 32'd4, 32'h0109_4020, 1'b0, 32'd4);
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, "stall_1", 32'd4, 32'h0109_4020, 1'b0, 32'd4);
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, "stall_2", 32'd4, 32'h0109_4020, 1'b0, 32'd4);
    step(1'b1, 1'b1, 1'b0, 32'h0,  1'b1, "stall_flush", 32'd4, 32'h0, 1'b0, 32'd4);
    run("s_resume", 32'd8, 32'h8C22_0004, 1'b0, 32'd8);

    // 4: enable low for 3 cycles (jump asserted to show it is ignored)
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, "frz_1", 32'd8, 32'h8C22_0004, 1'b0, 32'd8);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, "frz_2", 32'd8, 32'h8C22_0004, 1'b0, 32'd8);
    step(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, "frz_3", 32'd8, 32'h8C22_0004, 1'b0, 32'd8);
    run("frz_resume", 32'd12, 32'h0, 1'b0, 32'd12);
    run("frz_halt",   32'd16, 32'hFFFF_FFFF, 1'b1, 32'd16);

    // 5: HALT at 0x40; squashed HALT at PC=12 must not halt
    do_reset("reset_halt_test");
    load(10'd16, 32'hFFFF_FFFF);
    run("h_pc0", 32'd4,  32'h0109_4020, 1'b0, 32'd4);
    run("h_pc4", 32'd8,  32'h8C22_0004, 1'b0, 32'd8);
    run("h_pc8", 32'd12, 32'h0,         1'b0, 32'd12);
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, "h_squash", 32'd16, 32'h0, 1'b0, 32'h40);
    run("h_at40",   32'h44, 32'hFFFF_FFFF, 1'b1, 32'h44);
    run("h_frozen", 32'h44, 32'hFFFF_FFFF, 1'b1, 32'h44);

    // Flush alone on a non-halt fetch
    do_reset("reset_flush");
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "flush_only", 32'd4, 32'h0, 1'b0, 32'd4);
    run("flush_next", 32'd8, 32'h8C22_0004, 1'b0, 32'd8);

    // Write to the word being fetched: old data latched, new data next time
    do_reset("reset_wr");
    run("w_pc0", 32'd4, 32'h0109_4020, 1'b0, 32'd4);
    i_wr_en = 1'b1; i_wr_addr = 10'd1; i_wr_data = 32'hAAAA_5555;
    run("w_same_cycle", 32'd8, 32'h8C22_0004, 1'b0, 32'd8);
    i_wr_en = 1'b0;
    do_reset("reset_wr2");
    run("w_pc0b", 32'd4, 32'h0109_4020, 1'b0, 32'd4);
    run("w_new",  32'd8, 32'hAAAA_5555, 1'b0, 32'd8);

    // Address wrap beyond depth, low PC bits ignored: 0x1003 -> word 0
    step(1'b1, 1'b0, 1'b1, 32'h1003, 1'b0, "wrap_jump", 32'd12, 32'h0, 1'b0, 32'h1003);
    run("wrap_fetch", 32'h1007, 32'h0109_4020, 1'b0, 32'h1007);

    // PC adder wraps mod 2^32
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, "pcmax_jump", 32'h100B, 32'h0, 1'b0, 32'hFFFF_FFFC);
    // 0xFFFFFFFC -> word 0x3FF (unwritten); avoid checking its contents: flush it
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "pc_wrap", 32'h0, 32'h0, 1'b0, 32'h0);
    run("pc_wrap_fetch", 32'd4, 32'h0109_4020, 1'b0, 32'd4);

    @(negedge i_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
